// File: rtl/wb_bus_splitter_n_if.sv
// Wishbone signal bundle between the upstream master, the splitter and its N slaves.
// The splitter uses the "slave" view (it is the slave of the upstream master); the environment uses "master".
interface wb_bus_splitter_n_if #(
  parameter int N_SLAVES = 4
);
  logic [31:0]            m_adr_i;
  logic [31:0]            m_dat_i;
  logic [3:0]             m_sel_i;
  logic                   m_we_i;
  logic                   m_stb_i;
  logic                   m_cyc_i;
  logic [31:0]            m_dat_o;
  logic                   m_ack_o;
  logic                   m_err_o;
  logic [31:0]            s_adr_o;
  logic [31:0]            s_dat_o;
  logic [3:0]             s_sel_o;
  logic                   s_we_o;
  logic [N_SLAVES-1:0]    s_cyc_o;
  logic [N_SLAVES-1:0]    s_stb_o;
  logic [32*N_SLAVES-1:0] s_dat_i;
  logic [N_SLAVES-1:0]    s_ack_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/wb_bus_splitter_n.sv
// N-slave Wishbone B4 classic splitter: base+window decode, registered slave select,
// error response for unmapped addresses and for slaves that never acknowledge.
module wb_bus_splitter_n #(
  parameter int          N_SLAVES        = 4,
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [31:0] SLAVE_ADDR_SIZE = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES  = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  wb_bus_splitter_n_if.slave bus,
  output logic               timeout_o,
  output logic [7:0]         err_cnt_o
);

  localparam int          SEL_W     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int          WIN_SHIFT = $clog2(SLAVE_ADDR_SIZE);
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(N_SLAVES) * {1'b0, SLAVE_ADDR_SIZE};
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RESP, ST_ERR} state_e;

  state_e              r_state, w_next;
  logic [SEL_W-1:0]    r_sel;
  logic [15:0]         r_cnt;
  logic [31:0]         r_dat;
  logic                r_timeout;
  logic [7:0]          r_err_cnt;

  logic                w_hit;
  logic [SEL_W-1:0]    w_idx;
  logic                w_ack_sel;
  logic                w_latch, w_capture, w_to_err, w_timeout;
  logic [N_SLAVES-1:0] w_strobe;

  // 33-bit compare so a window that ends exactly at 2^32 cannot wrap to a false hit.
  assign w_hit     = ({1'b0, bus.m_adr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.m_adr_i} < END_ADDR);
  assign w_idx     = SEL_W'((bus.m_adr_i - BASE_ADDR) >> WIN_SHIFT);
  assign w_ack_sel = bus.s_ack_i[r_sel];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    w_to_err  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          if (w_hit) begin
            w_latch = 1'b1;
            w_next  = ST_ACTIVE;
          end else begin
            w_to_err = 1'b1;
            w_next   = ST_ERR;
          end
        end
      end
      ST_ACTIVE: begin
        // Abort beats ack, and ack beats a timeout landing on the same cycle.
        if (!bus.m_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_ack_sel) begin
          w_capture = 1'b1;
          w_next    = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_to_err  = 1'b1;
          w_timeout = 1'b1;
          w_next    = ST_ERR;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_sel     <= '0;
      r_cnt     <= '0;
      r_dat     <= '0;
      r_timeout <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_timeout <= w_timeout;
      if (w_latch) begin
        r_sel <= w_idx;
        r_cnt <= '0;
      end else if (r_state == ST_ACTIVE) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_capture)     r_dat <= bus.s_dat_i[32*r_sel +: 32];
      else if (w_to_err) r_dat <= '0;
      if (w_to_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  always_comb begin
    w_strobe = '0;
    if (r_state == ST_ACTIVE) w_strobe[r_sel] = 1'b1;
  end

  assign bus.s_cyc_o = w_strobe;
  assign bus.s_stb_o = w_strobe;
  assign bus.s_adr_o = bus.m_adr_i;
  assign bus.s_dat_o = bus.m_dat_i;
  assign bus.s_sel_o = bus.m_sel_i;
  assign bus.s_we_o  = bus.m_we_i;
  assign bus.m_dat_o = r_dat;
  assign bus.m_ack_o = (r_state == ST_RESP);
  assign bus.m_err_o = (r_state == ST_ERR);
  assign timeout_o   = r_timeout;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_wb_bus_splitter_n.sv
// Directed bench for wb_bus_splitter_n (N=4, timeout 8): decode, read/write, errors,
// timeout race, abort, error-counter saturation and asynchronous reset.
module tb_wb_bus_splitter_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       timeout;
  logic [7:0] err_cnt;
  int         checks = 0;
  int         failures = 0;

  wb_bus_splitter_n_if #(.N_SLAVES(4)) bus ();

  wb_bus_splitter_n #(
    .N_SLAVES(4), .BASE_ADDR(32'h3000_0000), .SLAVE_ADDR_SIZE(32'h0001_0000), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus.slave), .timeout_o(timeout), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic start(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    bus.m_adr_i = adr; bus.m_we_i = we; bus.m_dat_i = dat;
    bus.m_sel_i = 4'hF; bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
  endtask

  task automatic stop();
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; bus.s_ack_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stop();
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = 1'b0;
    bus.s_dat_i = {32'hDEAD_BEEF, 32'h2222_2222, 32'hA5A5_0001, 32'h0BAD_F00D};
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, timeout, err_cnt, bus.m_dat_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ack=%b err=%b cyc=%b stb=%b to=%b cnt=%h dat=%h required all 0",
               bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, timeout, err_cnt, bus.m_dat_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0000 || bus.m_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset stb=%b ack=%b required 0000/0", bus.s_stb_o, bus.m_ack_o);
    end
  endtask

  task automatic test_read();
    start(32'h3001_0004, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0010 || bus.s_cyc_o !== 4'b0010) begin
      failures++;
      $display("FAIL rd_stb_c0 stb=%b cyc=%b required 0010", bus.s_stb_o, bus.s_cyc_o);
    end
    bus.s_ack_i = 4'b0100;                       // unselected slave acks: must be ignored
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0010 || bus.m_ack_o !== 1'b0 || bus.m_err_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_stb_c1 stb=%b ack=%b err=%b required 0010/0/0", bus.s_stb_o, bus.m_ack_o, bus.m_err_o);
    end
    bus.s_ack_i = 4'b0010;
    @(negedge clk);
    bus.s_ack_i = '0;
    checks++;
    if (bus.m_ack_o !== 1'b1 || bus.m_err_o !== 1'b0 || bus.m_dat_o !== 32'hA5A5_0001 || bus.s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL rd_resp ack=%b err=%b dat=%h stb=%b required 1/0/a5a50001/0000",
               bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.s_stb_o);
    end
    stop();
    @(negedge clk);
    checks++;
    if (bus.m_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_ack_one_cycle ack=%b required 0", bus.m_ack_o);
    end
  endtask

  task automatic test_write();
    start(32'h3003_FFFC, 1'b1, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b1000 || bus.s_dat_o !== 32'h1234_5678 || bus.s_we_o !== 1'b1 ||
        bus.s_adr_o !== 32'h3003_FFFC || bus.s_sel_o !== 4'hF) begin
      failures++;
      $display("FAIL wr_slave_side stb=%b dat=%h we=%b adr=%h sel=%h required 1000/12345678/1/3003fffc/f",
               bus.s_stb_o, bus.s_dat_o, bus.s_we_o, bus.s_adr_o, bus.s_sel_o);
    end
    bus.s_ack_i = 4'b1000;
    @(negedge clk);
    bus.s_ack_i = '0;
    checks++;
    if (bus.m_ack_o !== 1'b1 || bus.m_err_o !== 1'b0 || bus.m_dat_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_resp ack=%b err=%b dat=%h required 1/0/deadbeef", bus.m_ack_o, bus.m_err_o, bus.m_dat_o);
    end
    stop();
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = 32'h3004_0000;
    addrs[1] = 32'h2FFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      start(addrs[i], 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.m_err_o !== 1'b1 || bus.m_ack_o !== 1'b0 || bus.s_stb_o !== 4'b0000 ||
          bus.m_dat_o !== 32'h0 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL unmapped_%0d err=%b ack=%b stb=%b dat=%h to=%b required 1/0/0000/0/0",
                 i, bus.m_err_o, bus.m_ack_o, bus.s_stb_o, bus.m_dat_o, timeout);
      end
      stop();
      @(negedge clk);
      checks++;
      if (bus.m_err_o !== 1'b0 || bus.s_stb_o !== 4'b0000) begin
        failures++;
        $display("FAIL unmapped_done_%0d err=%b stb=%b required 0/0000", i, bus.m_err_o, bus.s_stb_o);
      end
    end
    checks++;
    if (err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL unmapped_err_cnt got=%0d required 2", err_cnt);
    end
  endtask

  task automatic test_timeout();
    int got = 0;
    logic stb_ok = 1'b1;
    start(32'h3002_0000, 1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.m_err_o || bus.m_ack_o) begin
        got = i;
        break;
      end
      if (bus.s_stb_o !== 4'b0100) stb_ok = 1'b0;
    end
    checks++;
    if (got != 9 || !stb_ok) begin
      failures++;
      $display("FAIL timeout_latency cycles_after_stb=%0d stb_ok=%b required 8/1", got - 1, stb_ok);
    end
    checks++;
    if (bus.m_err_o !== 1'b1 || bus.m_ack_o !== 1'b0 || timeout !== 1'b1 || bus.s_stb_o !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_resp err=%b ack=%b to=%b stb=%b required 1/0/1/0000",
               bus.m_err_o, bus.m_ack_o, timeout, bus.s_stb_o);
    end
    stop();
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || bus.m_err_o !== 1'b0 || err_cnt !== 8'd3) begin
      failures++;
      $display("FAIL timeout_pulse to=%b err=%b cnt=%0d required 0/0/3", timeout, bus.m_err_o, err_cnt);
    end
  endtask

  task automatic test_ack_on_timeout();
    start(32'h3000_0000, 1'b0, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) bus.s_ack_i = 4'b0001;           // counter sits at TIMEOUT_CYCLES-1 here
    end
    @(negedge clk);
    bus.s_ack_i = '0;
    checks++;
    if (bus.m_ack_o !== 1'b1 || bus.m_err_o !== 1'b0 || timeout !== 1'b0 || bus.m_dat_o !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL ack_beats_timeout ack=%b err=%b to=%b dat=%h required 1/0/0/0badf00d",
               bus.m_ack_o, bus.m_err_o, timeout, bus.m_dat_o);
    end
    stop();
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic quiet = 1'b1;
    start(32'h3001_0000, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0010) begin
      failures++;
      $display("FAIL abort_active stb=%b required 0010", bus.s_stb_o);
    end
    stop();
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0000 || bus.s_cyc_o !== 4'b0000) begin
      failures++;
      $display("FAIL abort_drop stb=%b cyc=%b required 0000", bus.s_stb_o, bus.s_cyc_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.m_ack_o || bus.m_err_o) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet || err_cnt !== 8'd3) begin
      failures++;
      $display("FAIL abort_no_resp quiet=%b cnt=%0d required 1/3", quiet, err_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 260; i++) begin
      start(32'h4000_0000, 1'b0, 32'h0);
      @(negedge clk);
      if (i == 251) begin
        checks++;
        if (err_cnt !== 8'hFE) begin
          failures++;
          $display("FAIL sat_pre got=%h required fe", err_cnt);
        end
      end
      if (i == 252) begin
        checks++;
        if (err_cnt !== 8'hFF) begin
          failures++;
          $display("FAIL sat_reach got=%h required ff", err_cnt);
        end
      end
      stop();
      @(negedge clk);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL sat_hold got=%h required ff", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet = 1'b1;
    start(32'h3001_0000, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, timeout, err_cnt, bus.m_dat_o} !== '0) begin
      failures++;
      $display("FAIL reset_mid ack=%b err=%b cyc=%b stb=%b to=%b cnt=%h dat=%h required all 0",
               bus.m_ack_o, bus.m_err_o, bus.s_cyc_o, bus.s_stb_o, timeout, err_cnt, bus.m_dat_o);
    end
    stop();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.m_ack_o || bus.m_err_o || bus.s_stb_o != 4'b0000) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL reset_mid_no_ack quiet=%b required 1", quiet);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_ack_on_timeout();
    test_abort();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
